hls_mac_driver: RTL
===================

HLS_MAC_DRIVER -- requirements
Module: hls_mac_driver

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter FIFO_DEPTH, default 8 (power of two, >=2), result buffer entries and maximum outstanding credits.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles with work in flight and no k_done before error.
REQ-004 ap_clk  in  1  single clock; all logic on rising edge.
REQ-005 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 s_valid / s_ready  in / out  1 / 1  operand-stream handshake.
REQ-007 s_a, s_b, s_c  in  DATA_WIDTH each  operand triple.
REQ-008 k_start  out  1  one-cycle start pulse per operand triple sent to the kernel.
REQ-009 k_a, k_b, k_c  out  DATA_WIDTH each  registered operands, valid in the k_start cycle.
REQ-010 k_done / k_result  in / in  1 / DATA_WIDTH  kernel completion pulse and result.
REQ-011 m_valid / m_ready / m_data  out / in / out  1 / 1 / DATA_WIDTH  result-stream handshake.
REQ-012 flush  in  1  request to stop accepting and drain.
REQ-013 inflight  out  $clog2(FIFO_DEPTH)+1  triples issued and not yet completed.
REQ-014 busy / err  out / out  1 / 1  state not IDLE; sticky error flag.

Function
REQ-015 States: IDLE, ACTIVE, DRAIN, ERROR.
REQ-016 IDLE->ACTIVE on s_valid && !flush; ACTIVE->DRAIN on flush; DRAIN->IDLE when inflight==0 && fifo empty; any state->ERROR on error event.
REQ-017 credit = FIFO_DEPTH - (inflight + fifo_count); s_ready = (state is IDLE or ACTIVE) && !flush && credit>0.
REQ-018 On s_valid && s_ready, k_start=1 next cycle with k_a/k_b/k_c = captured operands; kernel latency is independent of this block (no fixed latency assumed), initiation interval 1.
REQ-019 k_start never asserted two cycles for one triple; back-to-back accepts give back-to-back pulses.
REQ-020 inflight +1 on issue, -1 on k_done, unchanged when both occur in the same cycle.
REQ-021 On k_done, k_result is pushed into the result FIFO in that cycle; results are delivered in issue order.
REQ-022 Credit accounting guarantees the FIFO never overflows; a push to a full FIFO is therefore an error event.
REQ-023 m_valid = fifo not empty; m_data = FIFO head; pop on m_valid && m_ready; push and pop in the same cycle leave the count unchanged, including when full.
REQ-024 Error events: k_done with inflight==0; push with FIFO full; timeout counter reaching TIMEOUT (counter increments while inflight>0 and no k_done, and clears on k_done or inflight==0).
REQ-025 In ERROR: s_ready=0, k_start=0, err=1, FIFO still drains to m_*; only reset leaves ERROR.
REQ-026 flush asserted in IDLE with nothing outstanding is a no-op.

Reset
REQ-027 While ap_rst_n=0: state IDLE, s_ready=0, k_start=0, k_a/k_b/k_c=0, m_valid=0, m_data=0, inflight=0, busy=0, err=0, FIFO empty, timeout counter 0.
REQ-028 Reset mid-operation discards all outstanding and buffered results; k_done pulses arriving after reset with inflight==0 raise err.
REQ-029 s_ready is 1 in the first cycle after reset deassertion.

Structure
REQ-030 Package hls_ctrl_pkg holds the state enumeration and default width and depth constants.
REQ-031 Result buffer is sub-module hls_result_fifo (synchronous, first-word fall-through, with count output); control and credit logic sit in hls_mac_driver.

Verification
REQ-032 Single triple a=3, b=4, c=5, kernel model latency 6 returning a*b+c -> one k_start pulse, m_data=17, inflight 1->0.
REQ-033 Eight back-to-back triples with m_ready=0 and FIFO_DEPTH=8 -> eight k_start pulses, s_ready=0 after the 8th, results held in order; m_ready=1 drains all eight and s_ready returns to 1.
REQ-034 Issue and k_done in the same cycle with inflight=2 -> inflight stays 2.
REQ-035 Spurious k_done after reset -> err=1, state ERROR, s_ready=0 until reset.
REQ-036 Kernel model stalls with inflight=1 -> err=1 exactly TIMEOUT=64 cycles after the last progress.
REQ-037 flush with 3 in flight -> s_ready=0 immediately, busy=1 until the 3 results are popped, then IDLE.

Source files
------------

// File: rtl/hls_ctrl_pkg.sv
// Shared constants for the HLS MAC kernel driver: FSM state encodings and
// default sizing of the operand/result path.
package hls_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_TIMEOUT    = 64;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

endpackage

// File: rtl/hls_result_fifo.sv
// First-word fall-through result buffer with occupancy count; a push into a
// full buffer is dropped unless a pop frees the slot in the same cycle.
module hls_result_fifo
   import hls_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_FIFO_DEPTH
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst_n,
   input  logic                       push,
   input  logic [DATA_WIDTH-1:0]      push_data,
   input  logic                       pop,
   output logic [DATA_WIDTH-1:0]      head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count need a defined
   // value, and leaving the array unreset lets it map onto RAM.
   always_ff @(posedge ap_clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hls_mac_driver.sv
// Credit-based driver for a pipelined a*b+c kernel: issues operand triples,
// tracks work in flight, buffers results in order and detects protocol errors.
module hls_mac_driver
   import hls_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_WIDTH-1:0]       s_a,
   input  logic [DATA_WIDTH-1:0]       s_b,
   input  logic [DATA_WIDTH-1:0]       s_c,
   output logic                        k_start,
   output logic [DATA_WIDTH-1:0]       k_a,
   output logic [DATA_WIDTH-1:0]       k_b,
   output logic [DATA_WIDTH-1:0]       k_c,
   input  logic                        k_done,
   input  logic [DATA_WIDTH-1:0]       k_result,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [DATA_WIDTH-1:0]       m_data,
   input  logic                        flush,
   output logic [$clog2(FIFO_DEPTH):0] inflight,
   output logic                        busy,
   output logic                        err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW:0] DEPTH_U = (CW+1)'(FIFO_DEPTH);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic [TW-1:0] tmo_cnt;
   logic [CW:0]   used;
   logic          accept;
   logic          issue;
   logic          pop;
   logic          done_ok;
   logic          err_event;

   assign used = {1'b0, inflight} + {1'b0, fifo_count};

   // Gated by the raw reset so the stream sees no ready while held in reset.
   assign s_ready = ap_rst_n && ((state == ST_IDLE) || (state == ST_ACTIVE))
                    && !flush && (used < DEPTH_U);

   assign accept  = s_valid && s_ready;
   assign m_valid = !fifo_empty;
   assign pop     = m_valid && m_ready;
   assign done_ok = k_done && (inflight != '0);

   assign err_event = (k_done && (inflight == '0))
                    || (k_done && fifo_full && !pop)
                    || ((tmo_cnt == TW'(TIMEOUT - 1)) && (inflight != '0) && !k_done);

   assign issue = accept && !err_event;
   assign busy  = (state != ST_IDLE);
   assign err   = (state == ST_ERROR);

   hls_result_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .push      (done_ok),
      .push_data (k_result),
      .pop       (pop),
      .head      (m_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (s_valid && !flush) state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (flush) state_nxt = ST_DRAIN;
         ST_DRAIN:  if ((inflight == '0) && fifo_empty) state_nxt = ST_IDLE;
         default:   state_nxt = state;
      endcase
      if (err_event) state_nxt = ST_ERROR;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state    <= ST_IDLE;
         inflight <= '0;
         tmo_cnt  <= '0;
         k_start  <= 1'b0;
         k_a      <= '0;
         k_b      <= '0;
         k_c      <= '0;
      end else begin
         state   <= state_nxt;
         k_start <= issue;
         if (issue) begin
            k_a <= s_a;
            k_b <= s_b;
            k_c <= s_c;
         end
         case ({issue, done_ok})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
         // Counts idle cycles of outstanding work; any completion is progress.
         if (k_done || (inflight == '0))
            tmo_cnt <= '0;
         else if (state != ST_ERROR)
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

endmodule
